// File: rtl/noc_pkg.sv
// Shared types and helpers for the router output-port logic.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tail_bit(input int num_bits);
        return num_bits - 1;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or above prio, wrapping modulo NUM_IN.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  prio,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [2*NUM_IN-1:0] req_shift;
    logic [NUM_IN-1:0]   req_rot;

    // Rotating a doubled copy puts the prio position at bit 0.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> prio;
    assign req_rot   = req_shift[NUM_IN-1:0];
    assign found     = |req;

    always_comb begin
        int pos;
        idx = '0;
        pos = 0;
        // Scan downward so the lowest rotated position is the last to win.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pos = int'(prio) + k;
                if (pos >= NUM_IN) pos = pos - NUM_IN;
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Packet-locked round-robin arbiter sharing one router output between NUM_IN input FIFOs.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int  NUM_IN   = 4,
    parameter int  NUM_BITS = 8,
    localparam int IDX_W    = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          req,
    input  logic [NUM_IN-1:0]          fifo_empty,
    input  logic [NUM_IN*NUM_BITS-1:0] fifo_data,
    output logic [NUM_IN-1:0]          rd_en,
    input  logic                       out_full,
    output logic [NUM_BITS-1:0]        out_data,
    output logic                       out_wr_en,
    output logic [NUM_IN-1:0]          grant,
    output logic                       busy,
    output logic [15:0]                flits_sent
);

    localparam int TAIL = tail_bit(NUM_BITS);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [IDX_W-1:0]    prio_q, prio_d;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [NUM_IN-1:0]   gidx_oh;
    logic [NUM_BITS-1:0] head_data;
    logic                rd_ok;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .prio  (prio_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        gidx_oh   = '0;
        head_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                gidx_oh[i] = 1'b1;
                head_data  = fifo_data[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // One read in flight at most: the XFER/DATA alternation keeps reads from running past a tail.
    assign rd_ok = ((gidx_oh & ~fifo_empty) != '0) && !out_full;

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        prio_d    = prio_q;
        rd_en     = '0;
        grant     = '0;
        busy      = 1'b0;
        out_wr_en = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = XFER;
                    gidx_d  = pick_idx;
                end
            end
            XFER: begin
                grant = gidx_oh;
                busy  = 1'b1;
                if (rd_ok) begin
                    rd_en   = gidx_oh;
                    state_d = DATA;
                end
            end
            DATA: begin
                grant     = gidx_oh;
                busy      = 1'b1;
                out_wr_en = 1'b1;
                out_data  = head_data;
                if (head_data[TAIL]) begin
                    state_d = IDLE;
                    prio_d  = (gidx_q == IDX_W'(NUM_IN - 1)) ? '0 : gidx_q + IDX_W'(1);
                end else begin
                    state_d = XFER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            gidx_q     <= '0;
            prio_q     <= '0;
            flits_sent <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            prio_q  <= prio_d;
            if (state_q == DATA) flits_sent <= flits_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter with registered-output input FIFO models.
module tb_noc_output_arbiter;

    localparam int NUM_IN   = 4;
    localparam int NUM_BITS = 8;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_IN-1:0]          req;
    logic [NUM_IN-1:0]          fifo_empty;
    logic [NUM_IN*NUM_BITS-1:0] fifo_data;
    logic [NUM_IN-1:0]          rd_en;
    logic                       out_full;
    logic [NUM_BITS-1:0]        out_data;
    logic                       out_wr_en;
    logic [NUM_IN-1:0]          grant;
    logic                       busy;
    logic [15:0]                flits_sent;

    logic [NUM_IN-1:0]   req_en;
    logic [NUM_BITS-1:0] mem [NUM_IN][64];
    logic [NUM_BITS-1:0] dout [NUM_IN] = '{default: '0};
    int                  wr_ptr [NUM_IN] = '{default: 0};
    int                  rd_ptr [NUM_IN] = '{default: 0};

    logic [NUM_BITS-1:0] obs_d [$];
    logic [NUM_IN-1:0]   obs_g [$];
    int                  obs_c [$];
    int                  cyc = 0;
    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  base;
    logic                found;

    noc_output_arbiter #(
        .NUM_IN   (NUM_IN),
        .NUM_BITS (NUM_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .rd_en      (rd_en),
        .out_full   (out_full),
        .out_data   (out_data),
        .out_wr_en  (out_wr_en),
        .grant      (grant),
        .busy       (busy),
        .flits_sent (flits_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input FIFOs: data appears on the cycle after rd_en; the writes to the output are logged.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rd_en[i]) begin
                dout[i]   <= mem[i][rd_ptr[i][5:0]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
        if (out_wr_en) begin
            obs_d.push_back(out_data);
            obs_g.push_back(grant);
            obs_c.push_back(cyc);
        end
    end

    always_comb begin
        fifo_data  = '0;
        fifo_empty = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            fifo_data[i*NUM_BITS +: NUM_BITS] = dout[i];
            fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
        end
    end

    assign req = req_en & ~fifo_empty;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        mem[ch][wr_ptr[ch][5:0]] = d;
        wr_ptr[ch] = wr_ptr[ch] + 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int max, input string tag);
        int k;
        k = 0;
        while (obs_d.size() < n && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(obs_d.size()), 32'(n));
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k;
        k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_busy(input int max, input string tag);
        int k;
        k = 0;
        while (!busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        req_en   = '0;
        out_full = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_flits", 32'(flits_sent), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // Single input, three-flit packet on input 2.
        base = obs_d.size();
        push(2, 8'h01); push(2, 8'h02); push(2, 8'h83);
        req_en = 4'b0100;
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rd_en", 32'(rd_en), 32'h4);
        wait_writes(base + 3, 20, "t1_writes");
        wait_idle(10, "t1_idle");
        check("t1_d0", 32'(obs_d[base]), 32'h01);
        check("t1_d1", 32'(obs_d[base+1]), 32'h02);
        check("t1_d2", 32'(obs_d[base+2]), 32'h83);
        check("t1_gap0", 32'(obs_c[base+1] - obs_c[base]), 32'd2);
        check("t1_gap1", 32'(obs_c[base+2] - obs_c[base+1]), 32'd2);
        check("t1_prio", 32'(dut.prio_q), 32'd3);
        check("t1_flits", 32'(flits_sent), 32'd3);
        req_en = '0;

        // Contention: four single-flit packets, rotation from prio 0.
        pulse_reset();
        base = obs_d.size();
        push(0, 8'h80); push(1, 8'h81); push(2, 8'h82); push(3, 8'h83);
        req_en = 4'b1111;
        wait_writes(base + 4, 40, "t2_writes");
        wait_idle(10, "t2_idle");
        for (int k = 0; k < 4; k++) begin
            check("t2_data", 32'(obs_d[base+k]), 32'h80 + 32'(k));
            check("t2_grant", 32'(obs_g[base+k]), 32'd1 << k);
        end
        check("t2_prio_wrap", 32'(dut.prio_q), 32'd0);
        check("t2_flits", 32'(flits_sent), 32'd4);
        req_en = '0;

        // Packet lock: input 0 requests while input 1 is mid-packet.
        pulse_reset();
        base = obs_d.size();
        push(1, 8'h10); push(1, 8'h11); push(1, 8'h92);
        req_en = 4'b0010;
        wait_busy(10, "t3_busy");
        @(negedge clk);
        push(0, 8'hA0);
        req_en = 4'b0011;
        @(negedge clk);
        check("t3_lock_grant", 32'(grant), 32'h2);
        wait_writes(base + 4, 40, "t3_writes");
        wait_idle(10, "t3_idle");
        check("t3_d0", 32'(obs_d[base]), 32'h10);
        check("t3_d1", 32'(obs_d[base+1]), 32'h11);
        check("t3_d2", 32'(obs_d[base+2]), 32'h92);
        check("t3_d3", 32'(obs_d[base+3]), 32'hA0);
        check("t3_g2", 32'(obs_g[base+2]), 32'h2);
        check("t3_g3", 32'(obs_g[base+3]), 32'h1);
        req_en = '0;

        // Stall on out_full, then on an empty FIFO mid-packet.
        out_full = 1'b1;
        push(3, 8'h31);
        req_en = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_full_rd_en", 32'(rd_en), 32'd0);
            check("t4_full_grant", 32'(grant), 32'h8);
        end
        out_full = 1'b0;
        #1;
        check("t4_rd_after_full", 32'(rd_en), 32'h8);
        @(negedge clk);
        check("t4_wr_en", 32'(out_wr_en), 32'd1);
        check("t4_data", 32'(out_data), 32'h31);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_empty_rd_en", 32'(rd_en), 32'd0);
            check("t4_empty_grant", 32'(grant), 32'h8);
        end
        push(3, 8'hB2);
        #1;
        check("t4_rd_after_empty", 32'(rd_en), 32'h8);
        @(negedge clk);
        out_full = 1'b1;
        #1;
        check("t4_full_in_data_wr", 32'(out_wr_en), 32'd1);
        check("t4_full_in_data_d", 32'(out_data), 32'hB2);
        @(negedge clk);
        out_full = 1'b0;
        wait_idle(10, "t4_idle");
        check("t4_prio_wrap", 32'(dut.prio_q), 32'd0);
        check("t4_flits", 32'(flits_sent), 32'd6);
        req_en = '0;

        // Reset in the middle of a four-flit packet.
        base = obs_d.size();
        push(2, 8'hC5);
        req_en = 4'b0100;
        wait_writes(base + 1, 20, "t5_pre_write");
        wait_idle(10, "t5_pre_idle");
        check("t5_pre_prio", 32'(dut.prio_q), 32'd3);
        push(1, 8'h41); push(1, 8'h42); push(1, 8'h43); push(1, 8'hC4);
        req_en = 4'b0010;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (out_wr_en && out_data == 8'h42) found = 1'b1;
        end
        check("t5_reach_data", 32'(found), 32'd1);
        rst_n = 1'b1;
        #1;
        check("t5_rst_rd_en", 32'(rd_en), 32'd0);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_wr_en", 32'(out_wr_en), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_flits", 32'(flits_sent), 32'd0);
        base = obs_d.size();
        push(3, 8'hD3);
        req_en = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_restart_grant", 32'(grant), 32'h2);
        wait_writes(base + 3, 40, "t5_writes");
        wait_idle(10, "t5_idle");
        check("t5_d0", 32'(obs_d[base]), 32'h43);
        check("t5_d1", 32'(obs_d[base+1]), 32'hC4);
        check("t5_d2", 32'(obs_d[base+2]), 32'hD3);
        check("t5_g2", 32'(obs_g[base+2]), 32'h8);
        check("t5_flits", 32'(flits_sent), 32'd3);
        req_en = '0;

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.flits_sent = 16'hFFFF;
        #1;
        release dut.flits_sent;
        #1;
        check("t6_preload", 32'(flits_sent), 32'hFFFF);
        base = obs_d.size();
        push(0, 8'hE0);
        req_en = 4'b0001;
        wait_writes(base + 1, 20, "t6_write");
        wait_idle(10, "t6_idle");
        check("t6_data", 32'(obs_d[base]), 32'hE0);
        check("t6_wrap", 32'(flits_sent), 32'h0);
        req_en = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
